uart_frame_parser: RTL
======================

UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

Interface
REQ-001 Parameter DBITS, 8, byte width from UART receiver.
REQ-002 Parameter TIMEOUT_CYCLES, 50000, max idle clk cycles between bytes inside a frame.
REQ-003 Parameter TO_BITS, 16, width of the inter-byte timeout counter.
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 rx_data  input  DBITS  byte from receiver; valid only when rx_done=1.
REQ-007 rx_done  input  1  one-cycle strobe, new byte on rx_data.
REQ-008 frame_valid  output  1  operands held stable and valid.
REQ-009 frame_ready  input  1  consumer accepts frame when frame_valid&frame_ready.
REQ-010 number1  output  DBITS  first operand.
REQ-011 number2  output  DBITS  second operand.
REQ-012 sel  output  3  operation code: 1=ADD, 2=SUB, 3=MUL, 4=DIV.
REQ-013 frame_error  output  1  one-cycle pulse on rejected frame.
REQ-014 error_code  output  2  0 none, 1 bad terminator, 2 bad sel, 3 timeout; held until next error or reset.
REQ-015 overrun  output  1  sticky: byte arrived while frame_valid=1; cleared by reset only.

Function
REQ-016 Frame format SHALL be: 0x0C header, number1, number2, sel byte, 0xFF terminator.
REQ-017 FSM states SHALL be IDLE, GET_N1, GET_N2, GET_SEL, GET_END, HOLD.
REQ-018 IDLE: rx_done with 0x0C -> GET_N1; any other byte ignored, no error.
REQ-019 GET_N1/GET_N2/GET_SEL: any byte on rx_done accepted as data (0x0C/0xFF included) and the state advances.
REQ-020 GET_END: 0xFF with sel byte in 0x01..0x04 -> HOLD; 0xFF with other sel byte -> IDLE, error_code=2; non-0xFF -> IDLE, error_code=1.
REQ-021 frame_valid SHALL assert the cycle after the terminator strobe and stay high with operands stable until the frame_valid&frame_ready cycle, then HOLD -> IDLE.
REQ-022 Operand registers SHALL update only from a fully validated frame; partial/failed frames never alter outputs.
REQ-023 sel output = sel byte[2:0] of the accepted frame.
REQ-024 Timeout counter SHALL clear on every rx_done and count in GET_N1..GET_END; reaching TIMEOUT_CYCLES -> IDLE, error_code=3.
REQ-025 Counter SHALL not run in IDLE or HOLD; it SHALL saturate, never wrap.
REQ-026 In HOLD, rx_done SHALL set overrun and drop the byte; if frame_ready is high in the same cycle, the frame is still consumed and the byte is still dropped.
REQ-027 Same-cycle timeout and rx_done: the byte wins and the timeout is cancelled.
REQ-028 frame_error SHALL pulse exactly one cycle per rejected frame, coincident with the error_code update.

Reset
REQ-029 Asserting reset at any time SHALL force IDLE and clear counter, number1, number2, sel, frame_valid, frame_error, error_code, overrun to 0, including mid-frame and in HOLD.
REQ-030 After reset release the first accepted byte SHALL be a header seen in IDLE.

Structure
REQ-031 Shared package SHALL hold the header (0x0C) and terminator (0xFF) constants, the sel op-code constants ADD/SUB/MUL/DIV, and the error-code enumeration.
REQ-032 The FSM state typedef SHALL be local to the module.
REQ-033 No sub-module; the timeout counter is inline.

Verification
REQ-034 Bytes 0C,05,03,01,FF, frame_ready=1 -> frame_valid one cycle after the FF strobe; number1=5, number2=3, sel=1, no error.
REQ-035 Bytes 0C,10,20,07,FF -> frame_error pulse, error_code=2, outputs unchanged, state IDLE.
REQ-036 Bytes 0C,01,02,03,AA -> error_code=1; a following valid frame 0C,09,04,04,FF is accepted with sel=4.
REQ-037 Bytes 0C,01 then no byte for TIMEOUT_CYCLES (set to 20) -> error_code=3 at count 20; a byte at exactly count 20 is accepted instead (REQ-027).
REQ-038 Valid frame with frame_ready=0, then byte 0x0C arrives -> overrun=1, frame still held; frame_ready=1 -> IDLE.
REQ-039 Reset asserted after 0C,05 -> all outputs 0 asynchronously; then 0C,02,02,02,FF -> number1=2, number2=2, sel=2.

Source files
------------

// File: rtl/uart_frame_parser_pkg.sv
// ---------------------------------------------------------------------------
// uart_frame_parser_pkg
// Shared constants for the UART command-frame parser:
//   - frame delimiters (header / terminator byte values)
//   - operation codes carried in the sel byte
//   - error-code enumeration reported on error_code
// ---------------------------------------------------------------------------
package uart_frame_parser_pkg;

   localparam logic [7:0] HDR_BYTE  = 8'h0C;
   localparam logic [7:0] TERM_BYTE = 8'hFF;

   localparam logic [2:0] SEL_ADD = 3'd1;
   localparam logic [2:0] SEL_SUB = 3'd2;
   localparam logic [2:0] SEL_MUL = 3'd3;
   localparam logic [2:0] SEL_DIV = 3'd4;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_TERM    = 2'd1,
      ERR_SEL     = 2'd2,
      ERR_TIMEOUT = 2'd3
   } err_code_t;

endpackage

// File: rtl/uart_frame_parser.sv
// ---------------------------------------------------------------------------
// uart_frame_parser
// Assembles 5-byte command frames (0x0C, number1, number2, sel, 0xFF) from a
// UART receiver byte stream and presents the validated operands with a
// valid/ready handshake.
//
// Ports
//   clk          in   clock, rising edge
//   reset        in   asynchronous active-high reset
//   rx_data      in   received byte, qualified by rx_done
//   rx_done      in   one-cycle strobe per received byte
//   frame_valid  out  operands valid and held stable
//   frame_ready  in   consumer takes the frame on frame_valid & frame_ready
//   number1      out  first operand
//   number2      out  second operand
//   sel          out  operation code (1 ADD, 2 SUB, 3 MUL, 4 DIV)
//   frame_error  out  one-cycle pulse per rejected frame
//   error_code   out  cause of last rejection, held until next error/reset
//   overrun      out  sticky: a byte arrived while a frame was being held
// ---------------------------------------------------------------------------
module uart_frame_parser
   import uart_frame_parser_pkg::*;
#(
   parameter int DBITS          = 8,
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int TO_BITS        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [DBITS-1:0] rx_data,
   input  logic             rx_done,
   output logic             frame_valid,
   input  logic             frame_ready,
   output logic [DBITS-1:0] number1,
   output logic [DBITS-1:0] number2,
   output logic [2:0]       sel,
   output logic             frame_error,
   output logic [1:0]       error_code,
   output logic             overrun
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_GET_N1,
      S_GET_N2,
      S_GET_SEL,
      S_GET_END,
      S_HOLD
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;

   // Staging registers: hold the frame under construction so that the
   // visible operands only change once the whole frame has been validated.
   logic [DBITS-1:0] r_n1_stg;
   logic [DBITS-1:0] r_n2_stg;
   logic [DBITS-1:0] r_sel_stg;

   logic [TO_BITS-1:0] r_to_cnt;

   logic [DBITS-1:0] r_number1;
   logic [DBITS-1:0] r_number2;
   logic [2:0]       r_sel;
   logic             r_frame_error;
   err_code_t        r_error_code;
   logic             r_overrun;

   logic             w_busy;
   logic             w_timeout;
   logic             w_is_hdr;
   logic             w_is_term;
   logic             w_sel_ok;
   logic             w_load;
   logic             w_err;
   err_code_t        w_err_code;
   logic             w_frame_valid;

   assign w_busy    = (r_state == S_GET_N1) || (r_state == S_GET_N2) ||
                      (r_state == S_GET_SEL) || (r_state == S_GET_END);
   assign w_is_hdr  = (rx_data == DBITS'(HDR_BYTE));
   assign w_is_term = (rx_data == DBITS'(TERM_BYTE));
   // The whole sel byte must be 1..4, not just its low three bits.
   assign w_sel_ok  = (r_sel_stg >= DBITS'(SEL_ADD)) &&
                      (r_sel_stg <= DBITS'(SEL_DIV));
   // A byte arriving in the same cycle as the limit cancels the timeout.
   assign w_timeout = w_busy && !rx_done &&
                      (r_to_cnt >= TO_BITS'(TIMEOUT_CYCLES));

   // ---------------- state register ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      w_state_nxt = r_state;
      if (w_timeout) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:    if (rx_done && w_is_hdr) w_state_nxt = S_GET_N1;
            S_GET_N1:  if (rx_done) w_state_nxt = S_GET_N2;
            S_GET_N2:  if (rx_done) w_state_nxt = S_GET_SEL;
            S_GET_SEL: if (rx_done) w_state_nxt = S_GET_END;
            S_GET_END: if (rx_done) w_state_nxt = (w_is_term && w_sel_ok) ? S_HOLD : S_IDLE;
            S_HOLD:    if (frame_ready) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
         endcase
      end
   end

   // ---------------- output / control logic ----------------
   always_comb begin
      w_frame_valid = (r_state == S_HOLD);
      w_load        = 1'b0;
      w_err         = 1'b0;
      w_err_code    = ERR_NONE;
      if (w_timeout) begin
         w_err      = 1'b1;
         w_err_code = ERR_TIMEOUT;
      end else if (r_state == S_GET_END && rx_done) begin
         if (!w_is_term) begin
            w_err      = 1'b1;
            w_err_code = ERR_TERM;
         end else if (!w_sel_ok) begin
            w_err      = 1'b1;
            w_err_code = ERR_SEL;
         end else begin
            w_load     = 1'b1;
         end
      end
   end

   // Inter-byte timeout counter: idle outside the receive states, cleared by
   // every byte, saturating so a long stall can never wrap back under the limit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                  r_to_cnt <= '0;
      else if (!w_busy || rx_done) r_to_cnt <= '0;
      else if (r_to_cnt != '1)     r_to_cnt <= r_to_cnt + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_n1_stg  <= '0;
         r_n2_stg  <= '0;
         r_sel_stg <= '0;
      end else if (rx_done) begin
         if (r_state == S_GET_N1)  r_n1_stg  <= rx_data;
         if (r_state == S_GET_N2)  r_n2_stg  <= rx_data;
         if (r_state == S_GET_SEL) r_sel_stg <= rx_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_number1     <= '0;
         r_number2     <= '0;
         r_sel         <= '0;
         r_frame_error <= 1'b0;
         r_error_code  <= ERR_NONE;
         r_overrun     <= 1'b0;
      end else begin
         if (w_load) begin
            r_number1 <= r_n1_stg;
            r_number2 <= r_n2_stg;
            r_sel     <= r_sel_stg[2:0];
         end
         r_frame_error <= w_err;
         if (w_err) r_error_code <= w_err_code;
         // Bytes seen while holding are dropped, even on the consume cycle.
         if (r_state == S_HOLD && rx_done) r_overrun <= 1'b1;
      end
   end

   assign frame_valid = w_frame_valid;
   assign number1     = r_number1;
   assign number2     = r_number2;
   assign sel         = r_sel;
   assign frame_error = r_frame_error;
   assign error_code  = r_error_code;
   assign overrun     = r_overrun;

endmodule
